alu_cmd_seq: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 39 +++
 rtl/alu_seq_fifo.sv | 74 +++++++
 rtl/alu_cmd_seq.sv | 116 +++++++++++
 tb/tb_alu_cmd_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Opcode values follow the ALU judge encoding; commands travel as one packed word.
package alu_seq_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_NOT = 3'b010;
    localparam logic [OP_W-1:0] OP_AND = 3'b011;
    localparam logic [OP_W-1:0] OP_OR  = 3'b100;
    localparam logic [OP_W-1:0] OP_XOR = 3'b101;
    localparam logic [OP_W-1:0] OP_GT  = 3'b110;
    localparam logic [OP_W-1:0] OP_EQ  = 3'b111;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
    } alu_cmd_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] result;
        logic              overflow;
    } alu_res_t;

    function automatic alu_cmd_t make_cmd(input logic [OP_W-1:0]   op,
                                          input logic [DATA_W-1:0] x,
                                          input logic [DATA_W-1:0] y);
        alu_cmd_t c;
        c.op = op;
        c.x  = x;
        c.y  = y;
        return c;
    endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Command FIFO: DEPTH entries (power of two), head shown combinationally, zero when empty.
// Push is ignored while full and pop while empty; count is the exact occupancy.
module alu_seq_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  alu_cmd_t                 wr_cmd_i,
    input  logic                     pop_i,
    output alu_cmd_t                 head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    alu_cmd_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_cmd_i;
        end
    end

    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/alu_cmd_seq.sv
// Buffers (op,x,y) commands, drives the head onto an external ALU, registers its result.
// Latency: push at edge N into idle block -> result valid after edge N+1; one result/cycle.
// Backpressure: in_ready = FIFO not full (count only); out_* hold while stalled. Option: ALU_SEQ_ZERO_FLAG_EN adds out_zero.
module alu_cmd_seq
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_op,
    input  logic [DATA_W-1:0]      in_x,
    input  logic [DATA_W-1:0]      in_y,
    output logic [DATA_W-1:0]      alu_x,
    output logic [DATA_W-1:0]      alu_y,
    output logic [OP_W-1:0]        alu_judge,
    input  logic [DATA_W-1:0]      alu_result,
    input  logic                   alu_overflow,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_result,
    output logic                   out_overflow,
    output logic [OP_W-1:0]        out_op,
    output logic [$clog2(DEPTH):0] count
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic                   out_zero
`endif
);

    alu_cmd_t wr_cmd;
    alu_cmd_t head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     push;
    logic     cap;

    alu_res_t res_q, res_d;
    logic     out_valid_q, out_valid_d;

    assign wr_cmd   = make_cmd(in_op, in_x, in_y);
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    // Capture whenever a command is waiting and the output slot is free or draining.
    assign cap      = !fifo_empty && (!out_valid_q || out_ready);

    alu_seq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (push),
        .wr_cmd_i (wr_cmd),
        .pop_i    (cap),
        .head_o   (head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (count)
    );

    assign alu_x     = head.x;
    assign alu_y     = head.y;
    assign alu_judge = head.op;

    always_comb begin
        res_d       = res_q;
        out_valid_d = out_valid_q;
        if (cap) begin
            res_d.op       = head.op;
            res_d.result   = alu_result;
            res_d.overflow = alu_overflow;
            out_valid_d    = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_result   = res_q.result;
    assign out_overflow = res_q.overflow;
    assign out_op       = res_q.op;

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic zero_q, zero_d;

    always_comb begin
        zero_d = zero_q;
        if (cap) begin
            zero_d = (alu_result == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign out_zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed bench for alu_cmd_seq with a behavioural 8-bit ALU attached to its ALU ports.
module tb_alu_cmd_seq;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [7:0] in_x, in_y;
    logic [7:0] alu_x, alu_y;
    logic [2:0] alu_judge;
    logic [7:0] alu_result;
    logic       alu_overflow;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_overflow;
    logic [2:0] out_op;
    logic [2:0] count;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic       out_zero;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_cmd_seq #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_x         (in_x),
        .in_y         (in_y),
        .alu_x        (alu_x),
        .alu_y        (alu_y),
        .alu_judge    (alu_judge),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_op       (out_op),
        .count        (count)
`ifdef ALU_SEQ_ZERO_FLAG_EN
        ,
        .out_zero     (out_zero)
`endif
    );

    // Behavioural ALU: signed overflow for ADD/SUB, 0 otherwise.
    always_comb begin
        alu_result   = 8'h00;
        alu_overflow = 1'b0;
        case (alu_judge)
            OP_ADD: begin
                alu_result   = alu_x + alu_y;
                alu_overflow = (alu_x[7] == alu_y[7]) && (alu_result[7] != alu_x[7]);
            end
            OP_SUB: begin
                alu_result   = alu_x - alu_y;
                alu_overflow = (alu_x[7] != alu_y[7]) && (alu_result[7] != alu_x[7]);
            end
            OP_NOT:  alu_result = ~alu_x;
            OP_AND:  alu_result = alu_x & alu_y;
            OP_OR:   alu_result = alu_x | alu_y;
            OP_XOR:  alu_result = alu_x ^ alu_y;
            OP_GT:   alu_result = {7'b0, alu_x > alu_y};
            default: alu_result = {7'b0, alu_x == alu_y};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        in_valid = v;
        in_op    = op;
        in_x     = x;
        in_y     = y;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_result"}, 32'(out_result), 32'h00);
        chk({tag, "_out_overflow"}, 32'(out_overflow), 32'd0);
        chk({tag, "_out_op"}, 32'(out_op), 32'd0);
        chk({tag, "_alu_x"}, 32'(alu_x), 32'h00);
        chk({tag, "_alu_y"}, 32'(alu_y), 32'h00);
        chk({tag, "_alu_judge"}, 32'(alu_judge), 32'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        chk({tag, "_out_zero"}, 32'(out_zero), 32'd0);
`endif
    endtask

    logic [2:0] fill_op  [5];
    logic [7:0] fill_x   [5];
    logic [7:0] fill_y   [5];
    int         fill_cnt [5];
    logic       fill_rdy [5];
    logic [7:0] drain_res[4];
    logic [2:0] drain_op [4];
    int         drain_cnt[4];

    initial begin
        fill_op  = '{OP_ADD, OP_AND, OP_OR, OP_NOT, OP_GT};
        fill_x   = '{8'h01, 8'hF0, 8'h0F, 8'h55, 8'h09};
        fill_y   = '{8'h02, 8'h3C, 8'h30, 8'h00, 8'h03};
        fill_cnt = '{1, 1, 2, 3, 4};
        fill_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        drain_res = '{8'h30, 8'h3F, 8'hAA, 8'h01};
        drain_op  = '{OP_AND, OP_OR, OP_NOT, OP_GT};
        drain_cnt = '{3, 2, 1, 0};

        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        tick();
        tick();
        chk_reset_state("reset");
        rst_n = 1'b1;

        // Single ADD, output ready
        out_ready = 1'b1;
        drive(1'b1, OP_ADD, 8'h10, 8'h22);
        tick();
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        chk("add_count", 32'(count), 32'd1);
        chk("add_alu_x", 32'(alu_x), 32'h10);
        chk("add_alu_y", 32'(alu_y), 32'h22);
        chk("add_alu_judge", 32'(alu_judge), 32'(OP_ADD));
        chk("add_not_yet_valid", 32'(out_valid), 32'd0);
        tick();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_result", 32'(out_result), 32'h32);
        chk("add_op", 32'(out_op), 32'(OP_ADD));
        chk("add_ovf", 32'(out_overflow), 32'd0);
        chk("add_count_after", 32'(count), 32'd0);
        chk("add_alu_idle", 32'(alu_x), 32'h00);
        tick();
        chk("add_valid_clear", 32'(out_valid), 32'd0);
        chk("add_result_hold", 32'(out_result), 32'h32);

        // Fill with output stalled
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, fill_op[i], fill_x[i], fill_y[i]);
            tick();
            chk($sformatf("fill%0d_count", i), 32'(count), 32'(fill_cnt[i]));
            chk($sformatf("fill%0d_in_ready", i), 32'(in_ready), 32'(fill_rdy[i]));
        end
        chk("fill_first_result", 32'(out_result), 32'h03);
        chk("fill_first_op", 32'(out_op), 32'(OP_ADD));
        chk("fill_valid", 32'(out_valid), 32'd1);

        // Push attempt while full must be refused
        drive(1'b1, OP_XOR, 8'hFF, 8'h00);
        tick();
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        chk("full_refuse_count", 32'(count), 32'd4);

        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("stall%0d_result", i), 32'(out_result), 32'h03);
            chk($sformatf("stall%0d_op", i), 32'(out_op), 32'(OP_ADD));
            chk($sformatf("stall%0d_ovf", i), 32'(out_overflow), 32'd0);
            chk($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
        end

        // Drain: in_ready must not react combinationally to out_ready
        out_ready = 1'b1;
        #1;
        chk("drain_in_ready_comb", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("drain%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("drain%0d_result", i), 32'(out_result), 32'(drain_res[i]));
            chk($sformatf("drain%0d_op", i), 32'(out_op), 32'(drain_op[i]));
            chk($sformatf("drain%0d_count", i), 32'(count), 32'(drain_cnt[i]));
            chk($sformatf("drain%0d_in_ready", i), 32'(in_ready), 32'd1);
        end
        tick();
        chk("drain_end_valid", 32'(out_valid), 32'd0);
        chk("drain_end_hold", 32'(out_result), 32'h01);

        // SUB with signed overflow
        drive(1'b1, OP_SUB, 8'h80, 8'h01);
        tick();
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        tick();
        chk("sub_valid", 32'(out_valid), 32'd1);
        chk("sub_result", 32'(out_result), 32'h7F);
        chk("sub_ovf", 32'(out_overflow), 32'd1);
        chk("sub_op", 32'(out_op), 32'(OP_SUB));
        tick();
        chk("sub_valid_clear", 32'(out_valid), 32'd0);

        // Mid-stream reset with 3 buffered and one captured
        out_ready = 1'b0;
        drive(1'b1, OP_XOR, 8'h5A, 8'h5A);
        tick();
        drive(1'b1, OP_EQ, 8'h12, 8'h12);
        tick();
        chk("xor_result", 32'(out_result), 32'h00);
        chk("xor_op", 32'(out_op), 32'(OP_XOR));
`ifdef ALU_SEQ_ZERO_FLAG_EN
        chk("xor_zero", 32'(out_zero), 32'd1);
`endif
        drive(1'b1, OP_SUB, 8'h05, 8'h03);
        tick();
        drive(1'b1, OP_ADD, 8'hFF, 8'h01);
        tick();
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        chk("prerst_count", 32'(count), 32'd3);
        chk("prerst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        chk_reset_state("midrst");
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("postrst%0d_valid", i), 32'(out_valid), 32'd0);
            chk($sformatf("postrst%0d_count", i), 32'(count), 32'd0);
        end

        // Fresh command after reset
        drive(1'b1, OP_EQ, 8'h44, 8'h44);
        tick();
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        chk("eq_alu_judge", 32'(alu_judge), 32'(OP_EQ));
        chk("eq_alu_x", 32'(alu_x), 32'h44);
        tick();
        chk("eq_valid", 32'(out_valid), 32'd1);
        chk("eq_result", 32'(out_result), 32'h01);
        chk("eq_op", 32'(out_op), 32'(OP_EQ));
        chk("eq_ovf", 32'(out_overflow), 32'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        chk("eq_zero", 32'(out_zero), 32'd0);
`endif
        tick();
        chk("eq_valid_clear", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
